// File: rtl/bram2rgb.sv
// bram2rgb: 640x480@60 raster reader that scales a stored RGB888 frame by SCALE into the top-left of the screen.
module bram2rgb #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SRC_COLS = 320,
  parameter int SRC_ROWS = 180,
  parameter int SCALE    = 2
) (
  input  logic        pclk,
  input  logic        rst,
  output logic        bram_en,
  output logic [15:0] bram_addr,
  input  logic [23:0] bram_dout,
  output logic        o_Hsync,
  output logic        o_Vsync,
  output logic        vde,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        start_frame
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL  = 10'(V_TOTAL - 1);
  localparam logic [9:0] IW  = 10'(SRC_COLS * SCALE);
  localparam logic [9:0] IH  = 10'(SRC_ROWS * SCALE);
  localparam logic [15:0] COLS = 16'(SRC_COLS);
  localparam logic [1:0]  SMAX = 2'(SCALE - 1);

  if (SCALE < 1 || SCALE > 4 || SRC_COLS * SCALE > H_ACTIVE || SRC_ROWS * SCALE > V_ACTIVE ||
      SRC_COLS * SRC_ROWS > 65536) begin : g_param_err
    $error("bram2rgb: frame buffer geometry does not fit the raster or the 16-bit address");
  end

  logic [9:0]  h_cnt, v_cnt;
  logic [1:0]  hrep, vrep;
  logic [15:0] src_col, row_base;
  logic [4:0]  d1, d2;
  logic        h_wrap, v_wrap, v_in, inimg;
  logic [4:0]  s0;

  assign h_wrap = h_cnt == HL;
  assign v_wrap = v_cnt == VL;
  assign v_in   = v_cnt < IH;
  assign inimg  = h_cnt < IW && v_in;
  assign s0 = {inimg, h_cnt == '0 && v_cnt == '0, v_cnt >= VS0 && v_cnt < VS1,
               h_cnt >= HS0 && h_cnt < HS1, h_cnt < HA && v_cnt < VA};

  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
    end

  // Replicate counters stand in for division: src pixel = row_base + src_col.
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      hrep     <= '0;
      vrep     <= '0;
      src_col  <= '0;
      row_base <= '0;
    end else begin
      if (h_wrap) begin
        hrep    <= '0;
        src_col <= '0;
      end else if (inimg) begin
        hrep    <= hrep == SMAX ? '0 : hrep + 2'd1;
        src_col <= hrep == SMAX ? src_col + 16'd1 : src_col;
      end
      if (h_wrap && v_wrap) begin
        vrep     <= '0;
        row_base <= '0;
      end else if (h_wrap && v_in) begin
        vrep     <= vrep == SMAX ? '0 : vrep + 2'd1;
        row_base <= vrep == SMAX ? row_base + COLS : row_base;
      end
    end

  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      bram_en     <= 1'b0;
      bram_addr   <= '0;
      d1          <= '0;
      d2          <= '0;
      vde         <= 1'b0;
      o_Hsync     <= 1'b1;
      o_Vsync     <= 1'b1;
      start_frame <= 1'b0;
      {rgb_r, rgb_g, rgb_b} <= '0;
    end else begin
      bram_en     <= inimg;
      bram_addr   <= inimg ? row_base + src_col : bram_addr;
      d1          <= s0;
      d2          <= d1;
      vde         <= d2[0];
      o_Hsync     <= ~d2[1];
      o_Vsync     <= ~d2[2];
      start_frame <= d2[3];
      {rgb_r, rgb_g, rgb_b} <= d2[4] ? bram_dout : '0;
    end
endmodule

// File: tb/tb_bram2rgb.sv
// tb_bram2rgb: directed checks of a reduced-raster bram2rgb against an arithmetic pixel model.
module tb_bram2rgb;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int SC = 16, SR = 10, SCL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        pclk = 1'b0, rst = 1'b0;
  logic        bram_en, o_Hsync, o_Vsync, vde, start_frame;
  logic [15:0] bram_addr;
  logic [23:0] bram_dout;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  int          checks = 0, errors = 0;

  bram2rgb #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
             .SRC_COLS(SC), .SRC_ROWS(SR), .SCALE(SCL)) dut (
    .pclk(pclk), .rst(rst), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .o_Hsync(o_Hsync), .o_Vsync(o_Vsync), .vde(vde),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .start_frame(start_frame));

  always #5 pclk = ~pclk;

  // BRAM model: returns its address as data, one cycle after the registered request.
  always_ff @(posedge pclk) if (bram_en) bram_dout <= {8'h00, bram_addr};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_en"}, bram_en, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_hs"}, o_Hsync, 1);
    chk({tag, "_vs"}, o_Vsync, 1);
    chk({tag, "_vde"}, vde, 0);
    chk({tag, "_rgb"}, {rgb_r, rgb_g, rgb_b}, 0);
    chk({tag, "_sf"}, start_frame, 0);
  endtask

  function automatic bit img(int t);
    return (t % HT) < SC * SCL && ((t / HT) % VT) < SR * SCL;
  endfunction

  function automatic int addr(int t);
    return (((t / HT) % VT) / SCL) * SC + (t % HT) / SCL;
  endfunction

  task automatic run(string tag, int frames);
    int last_addr = 0, hs_l0 = 0, vs_f0 = 0, vde_f0 = 0, sf_n = 0, sf_prev = -1;
    for (int n = 1; n <= frames * FT + 3; n++) begin
      @(posedge pclk);
      #1;
      if (img(n - 1)) last_addr = addr(n - 1);
      chk({tag, "_bram_en"}, bram_en, 32'(img(n - 1)));
      chk({tag, "_bram_addr"}, bram_addr, last_addr);
      if (n < 3) begin
        chk({tag, "_early_vde"}, vde, 0);
        chk({tag, "_early_sf"}, start_frame, 0);
      end else begin
        int t, x, y;
        t = n - 3;
        x = t % HT;
        y = (t / HT) % VT;
        chk({tag, "_vde"}, vde, 32'(x < HA && y < VA));
        chk({tag, "_hsync"}, o_Hsync, 32'(!(x >= HA + HF && x < HA + HF + HS)));
        chk({tag, "_vsync"}, o_Vsync, 32'(!(y >= VA + VF && y < VA + VF + VS)));
        chk({tag, "_sf"}, start_frame, 32'(x == 0 && y == 0));
        chk({tag, "_rgb"}, {rgb_r, rgb_g, rgb_b}, img(t) ? addr(t) : 0);
        if (t < HT && o_Hsync === 1'b0) hs_l0++;
        if (t < FT && o_Vsync === 1'b0) vs_f0++;
        if (t < FT && vde === 1'b1) vde_f0++;
      end
      if (vde === 1'b0) chk({tag, "_blank_rgb"}, {rgb_r, rgb_g, rgb_b}, 0);
      if (start_frame === 1'b1) begin
        sf_n++;
        if (sf_prev >= 0) chk({tag, "_sf_period"}, n - sf_prev, FT);
        sf_prev = n;
      end
      if (n == 3) chk({tag, "_first_vde"}, {vde, start_frame}, 2'b11);
      if (n == 5) chk({tag, "_px2"}, {rgb_r, rgb_g, rgb_b}, 24'h000001);
      if (n == 34) chk({tag, "_px31"}, {rgb_r, rgb_g, rgb_b}, 24'h00000F);
      if (n == 35) chk({tag, "_px32_black"}, {vde, rgb_r, rgb_g, rgb_b}, 25'h1000000);
      if (n == 61) chk({tag, "_l1_px2"}, {rgb_r, rgb_g, rgb_b}, 24'h000001);
      if (n == 115) chk({tag, "_l2_px0"}, {rgb_r, rgb_g, rgb_b}, 24'h000010);
      if (n == 1098) chk({tag, "_last_px"}, {rgb_r, rgb_g, rgb_b}, 24'h00009F);
      if (n == 1123) chk({tag, "_l20_black"}, {vde, rgb_r, rgb_g, rgb_b}, 25'h1000000);
    end
    chk({tag, "_hs_low_cycles"}, hs_l0, HS);
    chk({tag, "_vs_low_cycles"}, vs_f0, VS * HT);
    chk({tag, "_vde_cycles"}, vde_f0, HA * VA);
    chk({tag, "_sf_count"}, sf_n, frames + 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    repeat (2) @(posedge pclk);
    #1 rst = 1'b0;
    run("run1", 2);
    repeat (300) @(posedge pclk);
    #1 chk("pre_reset_rgb", {vde, rgb_r, rgb_g, rgb_b}, 25'h100002A);
    #2 rst = 1'b1;
    #1 chk_reset("async");
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    run("run2", 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
